// File: rtl/highrun_pkg.sv
// Shared types and default widths for the programmable consecutive-high run monitor.
package highrun_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    RUN   = 2'd2
  } highrun_state_t;

  localparam int DEFAULT_CNT_W = 8;
  localparam int DEFAULT_EVT_W = 16;

endpackage

// File: rtl/highrun_evt_counter.sv
// Saturating event counter: counts inc pulses up to all-ones; clr has priority over inc.
module highrun_evt_counter #(
  parameter int EVT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [EVT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {EVT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/highrun_monitor.sv
// Consecutive-high run detector with a programmable threshold loaded over a config handshake.
// Optional run-entry counter is built only when HIGHRUN_EVT_CNT_EN is defined.
module highrun_monitor
  import highrun_pkg::*;
#(
  parameter int CNT_W          = DEFAULT_CNT_W,
  parameter int DEFAULT_THRESH = 2,
  parameter int EVT_W          = DEFAULT_EVT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_threshold,
  output logic             cfg_ready,
  output logic             run_out,
  output logic             run_start,
  input  logic             evt_clr,
  output logic [EVT_W-1:0] evt_count
);

  highrun_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] thresh;
  logic [CNT_W-1:0] cnt_inc;
  logic             run_out_q;
  logic             cfg_accept;

  // Config handshake: a threshold transfers on any rising edge where cfg_valid and
  // cfg_ready are both high; cfg_valid may be held and is taken in the first non-RUN cycle.
  assign cfg_ready  = (state != RUN);
  assign cfg_accept = cfg_valid && cfg_ready;
  assign cnt_inc    = cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      thresh <= CNT_W'(DEFAULT_THRESH);
    end else if (cfg_accept) begin
      // A zero threshold would never be reachable from IDLE, so it is treated as 1.
      thresh <= (cfg_threshold == '0) ? CNT_W'(1) : cfg_threshold;
      cnt    <= '0;
      state  <= IDLE;
    end else if (!data_in) begin
      cnt   <= '0;
      state <= IDLE;
    end else if (state != RUN) begin
      cnt   <= cnt_inc;
      state <= (cnt_inc == thresh) ? RUN : COUNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_out_q <= 1'b0;
    end else begin
      run_out_q <= run_out;
    end
  end

  assign run_out   = (state == RUN);
  assign run_start = run_out && !run_out_q;

`ifdef HIGHRUN_EVT_CNT_EN
  highrun_evt_counter #(
    .EVT_W (EVT_W)
  ) u_evt_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run_start),
    .clr   (evt_clr),
    .count (evt_count)
  );
`else
  logic unused_evt_clr;
  assign unused_evt_clr = evt_clr;
  assign evt_count      = '0;
`endif

endmodule
